// File: rtl/hc595_rx.sv
// Receive-side 74HC595 model: synchronizes the ds/shcp/stcp/oe link, shifts and latches
// the {seg, sel} word, and flags frames whose bit count is not exactly SHIFT_W.
module hc595_rx #(
  parameter int SHIFT_W     = 14,
  parameter int SEG_W       = 8,
  parameter int SEL_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               ds,
  input  logic               shcp,
  input  logic               stcp,
  input  logic               oe,
  output logic [SEG_W-1:0]   seg,
  output logic [SEL_W-1:0]   sel,
  output logic [SHIFT_W-1:0] word_q,
  output logic               latch_stb,
  output logic               frame_err,
  output logic [4:0]         bit_cnt
);

  if (SHIFT_W != SEG_W + SEL_W) begin : g_bad_width
    $error("hc595_rx: SHIFT_W must equal SEG_W + SEL_W");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("hc595_rx: SYNC_STAGES must be at least 2");
  end

  // Edges are ignored until the chains and the previous-value flops hold real input levels,
  // so a line already high at reset release never looks like a rising edge.
  localparam int SETTLE_N = SYNC_STAGES + 1;
  localparam int SETTLE_W = $clog2(SETTLE_N + 1);
  localparam logic [4:0] CNT_FRAME = 5'(SHIFT_W);

  logic [SYNC_STAGES-1:0] ds_sync_q,   ds_sync_d;
  logic [SYNC_STAGES-1:0] shcp_sync_q, shcp_sync_d;
  logic [SYNC_STAGES-1:0] stcp_sync_q, stcp_sync_d;
  logic [SYNC_STAGES-1:0] oe_sync_q,   oe_sync_d;
  logic                   shcp_prev_q, shcp_prev_d;
  logic                   stcp_prev_q, stcp_prev_d;
  logic [SETTLE_W-1:0]    settle_q,    settle_d;
  logic [SHIFT_W-1:0]     sreg_q,      sreg_d;
  logic [SHIFT_W-1:0]     word_d;
  logic [4:0]             bit_cnt_q,   bit_cnt_d;
  logic                   latch_stb_q, latch_stb_d;
  logic                   frame_err_q, frame_err_d;
  logic [SEG_W-1:0]       seg_q,       seg_d;
  logic [SEL_W-1:0]       sel_q,       sel_d;

  logic ds_s, shcp_s, stcp_s, oe_s;
  logic armed, shcp_edge, stcp_edge;

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c == 5'd31) ? c : c + 5'd1;
  endfunction

  always_comb begin
    ds_sync_d   = {ds_sync_q[SYNC_STAGES-2:0], ds};
    shcp_sync_d = {shcp_sync_q[SYNC_STAGES-2:0], shcp};
    stcp_sync_d = {stcp_sync_q[SYNC_STAGES-2:0], stcp};
    oe_sync_d   = {oe_sync_q[SYNC_STAGES-2:0], oe};

    ds_s   = ds_sync_q[SYNC_STAGES-1];
    shcp_s = shcp_sync_q[SYNC_STAGES-1];
    stcp_s = stcp_sync_q[SYNC_STAGES-1];
    oe_s   = oe_sync_q[SYNC_STAGES-1];

    shcp_prev_d = shcp_s;
    stcp_prev_d = stcp_s;

    armed     = (settle_q == SETTLE_W'(SETTLE_N));
    settle_d  = armed ? settle_q : settle_q + 1'b1;
    shcp_edge = armed && shcp_s && !shcp_prev_q;
    stcp_edge = armed && stcp_s && !stcp_prev_q;

    sreg_d      = shcp_edge ? {sreg_q[SHIFT_W-2:0], ds_s} : sreg_q;
    // A latch coinciding with a shift captures the pre-shift register and restarts the count at 1.
    word_d      = stcp_edge ? sreg_q : word_q;
    latch_stb_d = stcp_edge;
    frame_err_d = stcp_edge && (bit_cnt_q != CNT_FRAME);

    bit_cnt_d = bit_cnt_q;
    if (stcp_edge) begin
      bit_cnt_d = shcp_edge ? 5'd1 : 5'd0;
    end else if (shcp_edge) begin
      bit_cnt_d = sat_inc(bit_cnt_q);
    end

    seg_d = oe_s ? '1 : word_q[SHIFT_W-1 -: SEG_W];
    sel_d = oe_s ? '0 : word_q[SEL_W-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ds_sync_q   <= '0;
      shcp_sync_q <= '0;
      stcp_sync_q <= '0;
      oe_sync_q   <= '1;
      shcp_prev_q <= 1'b0;
      stcp_prev_q <= 1'b0;
      settle_q    <= '0;
      sreg_q      <= '0;
      word_q      <= '0;
      bit_cnt_q   <= 5'd0;
      latch_stb_q <= 1'b0;
      frame_err_q <= 1'b0;
      seg_q       <= '1;
      sel_q       <= '0;
    end else begin
      ds_sync_q   <= ds_sync_d;
      shcp_sync_q <= shcp_sync_d;
      stcp_sync_q <= stcp_sync_d;
      oe_sync_q   <= oe_sync_d;
      shcp_prev_q <= shcp_prev_d;
      stcp_prev_q <= stcp_prev_d;
      settle_q    <= settle_d;
      sreg_q      <= sreg_d;
      word_q      <= word_d;
      bit_cnt_q   <= bit_cnt_d;
      latch_stb_q <= latch_stb_d;
      frame_err_q <= frame_err_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign seg       = seg_q;
  assign sel       = sel_q;
  assign latch_stb = latch_stb_q;
  assign frame_err = frame_err_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_hc595_rx.sv
// Directed bench for hc595_rx: frame table plus hand sequences for gating, simultaneous
// edges, saturation and reset corner cases.
module tb_hc595_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        ds = 1'b0, shcp = 1'b0, stcp = 1'b0, oe = 1'b1;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic [13:0] word_q;
  logic        latch_stb, frame_err;
  logic [4:0]  bit_cnt;

  int checks = 0;
  int errors = 0;
  int stb_tot = 0;
  int err_tot = 0;

  hc595_rx #(.SHIFT_W(14), .SEG_W(8), .SEL_W(6), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .seg(seg), .sel(sel), .word_q(word_q), .latch_stb(latch_stb), .frame_err(frame_err),
    .bit_cnt(bit_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (latch_stb) stb_tot++;
    if (frame_err) err_tot++;
  end

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic [13:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_at_negedge(input string name, input logic [31:0] act, input logic [31:0] exp);
    @(negedge sys_clk);
    check(name, act, exp);
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    tick(2);
    shcp = 1'b1;
    tick(4);
    shcp = 1'b0;
    tick(2);
  endtask

  task automatic send(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(data[i]);
  endtask

  task automatic latch();
    stcp = 1'b1;
    tick(4);
    stcp = 1'b0;
    tick(4);
  endtask

  task automatic check_word(input string tag, input logic [13:0] w);
    check({tag, "_word"}, 32'(word_q), 32'(w));
    check({tag, "_seg"},  32'(seg),    32'(w[13:6]));
    check({tag, "_sel"},  32'(sel),    32'(w[5:0]));
  endtask

  initial begin
    int s0, e0;
    vecs[0] = '{32'h303E,  14, 14'h303E, 1'b0};
    vecs[1] = '{32'h1555,  14, 14'h1555, 1'b0};
    vecs[2] = '{32'h2AAA,  14, 14'h2AAA, 1'b0};
    vecs[3] = '{32'h0F0F,  13, 14'h0F0F, 1'b1};
    vecs[4] = '{32'hABCD,  16, 14'h2BCD, 1'b1};
    vecs[5] = '{32'h0000,   0, 14'h2BCD, 1'b1};
    vecs[6] = '{32'h3FFF,  14, 14'h3FFF, 1'b0};
    vecs[7] = '{32'h0000,  14, 14'h0000, 1'b0};

    // Reset with idle inputs
    tick(3);
    @(negedge sys_clk);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_sel", 32'(sel), 32'h00);
    check("rst_word", 32'(word_q), 32'h0);
    check("rst_bitcnt", 32'(bit_cnt), 32'h0);
    check("rst_pulses", 32'(stb_tot + err_tot), 32'h0);
    #1;
    sys_rst = 1'b0;
    oe = 1'b0;
    tick(6);
    check("post_rst_seg", 32'(seg), 32'h00);

    for (int v = 0; v < 8; v++) begin
      s0 = stb_tot;
      e0 = err_tot;
      send(vecs[v].data, vecs[v].nbits);
      check($sformatf("v%0d_bitcnt_pre", v), 32'(bit_cnt),
            32'((vecs[v].nbits > 31) ? 31 : vecs[v].nbits));
      latch();
      check_word($sformatf("v%0d", v), vecs[v].exp_word);
      check($sformatf("v%0d_stb", v), 32'(stb_tot - s0), 32'd1);
      check($sformatf("v%0d_err", v), 32'(err_tot - e0), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_bitcnt", v), 32'(bit_cnt), 32'd0);
    end

    // Output gating by oe
    send(32'h303E, 14);
    latch();
    check_word("oe_pre", 14'h303E);
    oe = 1'b1;
    tick(3);
    check_at_negedge("oe_seg_blank", 32'(seg), 32'hFF);
    check("oe_sel_blank", 32'(sel), 32'h00);
    check("oe_word_kept", 32'(word_q), 32'h303E);
    #1;
    oe = 1'b0;
    tick(3);
    check_at_negedge("oe_seg_restore", 32'(seg), 32'hC0);
    check("oe_sel_restore", 32'(sel), 32'h3E);
    #1;

    // 14th shift edge coincides with the latch edge
    s0 = stb_tot;
    e0 = err_tot;
    send(32'h1555, 13);
    ds = 1'b1;
    tick(2);
    shcp = 1'b1;
    stcp = 1'b1;
    tick(4);
    shcp = 1'b0;
    stcp = 1'b0;
    tick(4);
    check("sim_word", 32'(word_q), 32'h1555);
    check("sim_err", 32'(err_tot - e0), 32'd1);
    check("sim_stb", 32'(stb_tot - s0), 32'd1);
    check("sim_bitcnt", 32'(bit_cnt), 32'd1);
    e0 = err_tot;
    latch();
    check("sim_post_word", 32'(word_q), 32'h2AAB);
    check("sim_post_err", 32'(err_tot - e0), 32'd1);

    // bit_cnt saturation and extra shifts
    e0 = err_tot;
    send(32'hFFFF_FFFF, 32);
    shift_bit(1'b1);
    check("sat_bitcnt", 32'(bit_cnt), 32'd31);
    latch();
    check("sat_word", 32'(word_q), 32'h3FFF);
    check("sat_err", 32'(err_tot - e0), 32'd1);

    // Reset in the middle of a frame
    send(32'h7F, 7);
    sys_rst = 1'b1;
    tick(2);
    check_at_negedge("mid_rst_word", 32'(word_q), 32'h0);
    check("mid_rst_bitcnt", 32'(bit_cnt), 32'h0);
    check("mid_rst_seg", 32'(seg), 32'hFF);
    #1;
    sys_rst = 1'b0;
    tick(5);
    s0 = stb_tot;
    e0 = err_tot;
    send(32'h1555, 14);
    latch();
    check_word("mid_rst_frame", 14'h1555);
    check("mid_rst_err", 32'(err_tot - e0), 32'd0);
    check("mid_rst_stb", 32'(stb_tot - s0), 32'd1);

    // Lines already high at reset release must not register as edges
    shcp = 1'b1;
    stcp = 1'b1;
    sys_rst = 1'b1;
    tick(3);
    s0 = stb_tot;
    sys_rst = 1'b0;
    tick(8);
    check("hi_rel_bitcnt", 32'(bit_cnt), 32'd0);
    check("hi_rel_stb", 32'(stb_tot - s0), 32'd0);
    check("hi_rel_word", 32'(word_q), 32'h0);
    shcp = 1'b0;
    stcp = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
